// File: rtl/bus_arbiter.sv
// Two-master (instruction fetch / data) to one-slave Avalon-style bus arbiter.
// Serialises transactions, forwards slave stalls and routes read data back to its owner.
module bus_arbiter #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned DATA_PRIORITY = 1,
  localparam int unsigned BE_W         = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic              i_waitrequest,
  output logic [DATA_W-1:0] i_readdata,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [DATA_W-1:0] d_writedata,
  input  logic [BE_W-1:0]   d_byteenable,
  output logic              d_waitrequest,
  output logic [DATA_W-1:0] d_readdata,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  output logic [BE_W-1:0]   m_byteenable,
  input  logic              m_waitrequest,
  input  logic [DATA_W-1:0] m_readdata,
  output logic              busy,
  output logic              grant_d
);

  localparam int unsigned CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t            state_q, state_nxt;
  logic              own_d_q, own_d_nxt;   // 1: data master owns the bus
  logic              last_d_q, last_d_nxt; // 1: data master was served last
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [DATA_W-1:0] hold_i_q, hold_i_nxt;
  logic [DATA_W-1:0] hold_d_q, hold_d_nxt;

  logic req_i, req_d, own_req;
  logic done_i, done_d, rd_done_i, rd_done_d;

  assign req_i   = i_read;
  assign req_d   = d_read | d_write;
  assign own_req = own_d_q ? req_d : req_i;

  // State and data registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      own_d_q  <= 1'b0;
      last_d_q <= 1'b0;
      cnt_q    <= '0;
      hold_i_q <= '0;
      hold_d_q <= '0;
    end else begin
      state_q  <= state_nxt;
      own_d_q  <= own_d_nxt;
      last_d_q <= last_d_nxt;
      cnt_q    <= cnt_nxt;
      hold_i_q <= hold_i_nxt;
      hold_d_q <= hold_d_nxt;
    end
  end

  // Next state, arbitration and slave-side request mux
  always_comb begin
    state_nxt    = state_q;
    own_d_nxt    = own_d_q;
    last_d_nxt   = last_d_q;
    cnt_nxt      = cnt_q;
    hold_i_nxt   = hold_i_q;
    hold_d_nxt   = hold_d_q;
    m_address    = '0;
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_writedata  = '0;
    m_byteenable = '0;
    done_i       = 1'b0;
    done_d       = 1'b0;
    rd_done_i    = 1'b0;
    rd_done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_i || req_d) begin
          state_nxt = GRANT;
          if (req_i && req_d) own_d_nxt = (DATA_PRIORITY != 0) ? 1'b1 : ~last_d_q;
          else                own_d_nxt = req_d;
        end
      end
      GRANT: begin
        if (own_d_q) begin
          m_address    = d_address;
          m_write      = d_write;
          m_read       = d_read & ~d_write; // read+write together is a write
          m_writedata  = d_writedata;
          m_byteenable = d_byteenable;
        end else begin
          m_address    = i_address;
          m_read       = i_read;
          m_byteenable = '1;
        end
        if (!own_req) begin
          state_nxt = IDLE; // owner withdrew before accept
        end else if (!m_waitrequest) begin
          if (m_write) begin
            state_nxt  = IDLE;
            last_d_nxt = 1'b1;
            done_d     = 1'b1;
          end else begin
            state_nxt = RDWAIT;
            cnt_nxt   = CNT_W'(READ_LATENCY - 1);
          end
        end
      end
      RDWAIT: begin
        if (cnt_q == '0) begin
          state_nxt  = IDLE;
          last_d_nxt = own_d_q;
          if (own_d_q) begin
            done_d     = 1'b1;
            rd_done_d  = 1'b1;
            hold_d_nxt = m_readdata;
          end else begin
            done_i     = 1'b1;
            rd_done_i  = 1'b1;
            hold_i_nxt = m_readdata;
          end
        end else begin
          cnt_nxt = cnt_q - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign i_waitrequest = req_i & ~done_i;
  assign d_waitrequest = req_d & ~done_d;
  assign i_readdata    = rd_done_i ? m_readdata : hold_i_q;
  assign d_readdata    = rd_done_d ? m_readdata : hold_d_q;
  assign busy          = (state_q != IDLE);
  assign grant_d       = own_d_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: fixed-priority instance (u_pri) and round-robin instance (u_rr)
// share master-side stimulus; each has its own registered-read slave model.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] i_address, d_address, d_writedata;
  logic        i_read, d_read, d_write, m_waitrequest;
  logic [3:0]  d_byteenable;

  logic        p_i_wr, p_d_wr, p_m_read, p_m_write, p_busy, p_grant_d;
  logic [31:0] p_i_rd, p_d_rd, p_m_address, p_m_writedata, p_m_readdata;
  logic [3:0]  p_m_be;
  logic        r_i_wr, r_d_wr, r_m_read, r_m_write, r_busy, r_grant_d;
  logic [31:0] r_i_rd, r_d_rd, r_m_address, r_m_writedata, r_m_readdata;
  logic [3:0]  r_m_be;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1), .DATA_PRIORITY(1)) u_pri (
    .clk(clk), .reset_n(reset_n),
    .i_address(i_address), .i_read(i_read), .i_waitrequest(p_i_wr), .i_readdata(p_i_rd),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_waitrequest(p_d_wr), .d_readdata(p_d_rd),
    .m_address(p_m_address), .m_read(p_m_read), .m_write(p_m_write),
    .m_writedata(p_m_writedata), .m_byteenable(p_m_be), .m_waitrequest(m_waitrequest),
    .m_readdata(p_m_readdata), .busy(p_busy), .grant_d(p_grant_d)
  );

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1), .DATA_PRIORITY(0)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .i_address(i_address), .i_read(i_read), .i_waitrequest(r_i_wr), .i_readdata(r_i_rd),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_waitrequest(r_d_wr), .d_readdata(r_d_rd),
    .m_address(r_m_address), .m_read(r_m_read), .m_write(r_m_write),
    .m_writedata(r_m_writedata), .m_byteenable(r_m_be), .m_waitrequest(m_waitrequest),
    .m_readdata(r_m_readdata), .busy(r_busy), .grant_d(r_grant_d)
  );

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h2402_0005;
    return a ^ 32'h5A5A_0000;
  endfunction

  // Slave with one cycle of registered read latency
  always @(posedge clk) begin
    if (p_m_read && !m_waitrequest) p_m_readdata <= slave_data(p_m_address);
    if (r_m_read && !m_waitrequest) r_m_readdata <= slave_data(r_m_address);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (p_busy !== 1'b0)     $display("FAIL rst_busy: got %b exp 0", p_busy); else n_pass++;
    n_chk++; if (p_m_read !== 1'b0)   $display("FAIL rst_m_read: got %b exp 0", p_m_read); else n_pass++;
    n_chk++; if (p_m_write !== 1'b0)  $display("FAIL rst_m_write: got %b exp 0", p_m_write); else n_pass++;
    n_chk++; if (p_m_address !== 32'h0) $display("FAIL rst_m_addr: got %h exp 0", p_m_address); else n_pass++;
    n_chk++; if (p_m_be !== 4'h0)     $display("FAIL rst_m_be: got %h exp 0", p_m_be); else n_pass++;
    n_chk++; if (p_grant_d !== 1'b0)  $display("FAIL rst_grant_d: got %b exp 0", p_grant_d); else n_pass++;
    n_chk++; if (p_i_rd !== 32'h0)    $display("FAIL rst_i_rd: got %h exp 0", p_i_rd); else n_pass++;
    n_chk++; if (p_d_rd !== 32'h0)    $display("FAIL rst_d_rd: got %h exp 0", p_d_rd); else n_pass++;
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_i_read();
    int nrd = 0;
    cyc(); i_read = 1'b1; i_address = 32'hBFC0_0000;
    @(negedge clk); if (p_m_read) nrd++;
    n_chk++; if (p_i_wr !== 1'b1) $display("FAIL t1_c1_wait: got %b exp 1", p_i_wr); else n_pass++;
    cyc(); @(negedge clk); if (p_m_read) nrd++;
    n_chk++; if (p_m_address !== 32'hBFC0_0000) $display("FAIL t1_c2_addr: got %h exp bfc00000", p_m_address); else n_pass++;
    n_chk++; if (p_i_wr !== 1'b1) $display("FAIL t1_c2_wait: got %b exp 1", p_i_wr); else n_pass++;
    cyc(); @(negedge clk); if (p_m_read) nrd++;
    n_chk++; if (p_i_wr !== 1'b0) $display("FAIL t1_c3_wait: got %b exp 0", p_i_wr); else n_pass++;
    n_chk++; if (p_i_rd !== 32'h2402_0005) $display("FAIL t1_c3_data: got %h exp 24020005", p_i_rd); else n_pass++;
    cyc(); i_read = 1'b0;
    @(negedge clk);
    n_chk++; if (nrd !== 1) $display("FAIL t1_mread_cycles: got %0d exp 1", nrd); else n_pass++;
    n_chk++; if (p_i_rd !== 32'h2402_0005) $display("FAIL t1_hold: got %h exp 24020005", p_i_rd); else n_pass++;
  endtask

  task automatic test_priority();
    cyc();
    i_read = 1'b1; i_address = 32'h100;
    d_write = 1'b1; d_address = 32'h10; d_writedata = 32'hDEAD_BEEF; d_byteenable = 4'hF;
    @(negedge clk);
    n_chk++; if (p_m_write !== 1'b0) $display("FAIL t2_c1_idle: got %b exp 0", p_m_write); else n_pass++;
    cyc(); @(negedge clk);
    n_chk++; if (p_m_write !== 1'b1 || p_m_address !== 32'h10 || p_m_writedata !== 32'hDEAD_BEEF)
      $display("FAIL t2_c2_dwrite: got w=%b a=%h d=%h exp 1/10/deadbeef", p_m_write, p_m_address, p_m_writedata);
    else n_pass++;
    n_chk++; if (p_d_wr !== 1'b0) $display("FAIL t2_c2_dwait: got %b exp 0", p_d_wr); else n_pass++;
    n_chk++; if (p_i_wr !== 1'b1) $display("FAIL t2_c2_iwait: got %b exp 1", p_i_wr); else n_pass++;
    cyc(); d_write = 1'b0; d_byteenable = 4'h0;
    @(negedge clk);
    n_chk++; if (p_busy !== 1'b0 || p_m_read !== 1'b0) $display("FAIL t2_c3_gap: got busy=%b rd=%b exp 0/0", p_busy, p_m_read); else n_pass++;
    cyc(); @(negedge clk);
    n_chk++; if (p_m_read !== 1'b1 || p_grant_d !== 1'b0) $display("FAIL t2_c4_iread: got rd=%b gd=%b exp 1/0", p_m_read, p_grant_d); else n_pass++;
    cyc(); @(negedge clk);
    n_chk++; if (p_i_wr !== 1'b0 || p_i_rd !== 32'h5A5A_0100) $display("FAIL t2_c5_idone: got w=%b d=%h exp 0/5a5a0100", p_i_wr, p_i_rd); else n_pass++;
    cyc(); i_read = 1'b0;
  endtask

  task automatic test_round_robin();
    logic order [4];
    int   n = 0;
    reset_n = 1'b0;
    cyc(); reset_n = 1'b1;
    cyc();
    d_write = 1'b1; d_address = 32'h20; d_writedata = 32'h0; d_byteenable = 4'hF;
    i_read = 1'b1; i_address = 32'h40;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge clk);
      if (r_m_write && !m_waitrequest) begin order[n] = 1'b1; n++; end
      else if (r_m_read && !m_waitrequest) begin order[n] = 1'b0; n++; end
      cyc();
    end
    n_chk++; if (n !== 4) $display("FAIL t3_count: got %0d exp 4", n); else n_pass++;
    n_chk++; if (n == 4 && {order[0], order[1], order[2], order[3]} !== 4'b1010)
      $display("FAIL t3_order: got %b%b%b%b exp 1010 (1=D)", order[0], order[1], order[2], order[3]);
    else n_pass++;
    d_write = 1'b0; i_read = 1'b0; d_byteenable = 4'h0;
    repeat (3) cyc();
  endtask

  task automatic test_stall();
    cyc(); d_read = 1'b1; d_address = 32'h80; m_waitrequest = 1'b1;
    for (int c = 2; c <= 4; c++) begin
      cyc(); @(negedge clk);
      n_chk++; if (p_m_read !== 1'b1 || p_m_address !== 32'h80 || p_d_wr !== 1'b1)
        $display("FAIL t4_stall_c%0d: got rd=%b a=%h w=%b exp 1/80/1", c, p_m_read, p_m_address, p_d_wr);
      else n_pass++;
    end
    cyc(); m_waitrequest = 1'b0;
    @(negedge clk);
    n_chk++; if (p_d_wr !== 1'b1) $display("FAIL t4_accept_wait: got %b exp 1", p_d_wr); else n_pass++;
    cyc(); @(negedge clk);
    n_chk++; if (p_d_wr !== 1'b0 || p_d_rd !== 32'h5A5A_0080) $display("FAIL t4_done: got w=%b d=%h exp 0/5a5a0080", p_d_wr, p_d_rd); else n_pass++;
    cyc(); d_read = 1'b0;
  endtask

  task automatic test_byteenable();
    cyc(); d_write = 1'b1; d_address = 32'h30; d_writedata = 32'h1122_3344; d_byteenable = 4'b0010;
    @(negedge clk);
    n_chk++; if (p_m_be !== 4'h0) $display("FAIL t5_idle_be: got %h exp 0", p_m_be); else n_pass++;
    cyc(); @(negedge clk);
    n_chk++; if (p_m_be !== 4'b0010 || p_m_writedata !== 32'h1122_3344 || p_d_wr !== 1'b0)
      $display("FAIL t5_dwrite: got be=%b d=%h w=%b exp 0010/11223344/0", p_m_be, p_m_writedata, p_d_wr);
    else n_pass++;
    cyc(); d_write = 1'b0; d_byteenable = 4'h0; i_read = 1'b1; i_address = 32'h50;
    @(negedge clk);
    n_chk++; if (p_d_rd !== 32'h5A5A_0080) $display("FAIL t5_d_hold: got %h exp 5a5a0080", p_d_rd); else n_pass++;
    cyc(); @(negedge clk);
    n_chk++; if (p_m_be !== 4'hF || p_m_read !== 1'b1 || p_m_write !== 1'b0)
      $display("FAIL t5_iread_be: got be=%b rd=%b wr=%b exp 1111/1/0", p_m_be, p_m_read, p_m_write);
    else n_pass++;
    cyc(); @(negedge clk);
    n_chk++; if (p_i_rd !== 32'h5A5A_0050) $display("FAIL t5_idata: got %h exp 5a5a0050", p_i_rd); else n_pass++;
    cyc(); i_read = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    int  nrd  = 0;
    logic got = 1'b0;
    cyc(); i_read = 1'b1; i_address = 32'h60;
    cyc();
    cyc();
    n_chk++; if (p_busy !== 1'b1) $display("FAIL t6_in_rdwait: got busy=%b exp 1", p_busy); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_chk++; if (p_m_read !== 1'b0 || p_busy !== 1'b0) $display("FAIL t6_async: got rd=%b busy=%b exp 0/0", p_m_read, p_busy); else n_pass++;
    n_chk++; if (p_i_rd !== 32'h0 || p_i_wr !== 1'b1) $display("FAIL t6_rst_out: got d=%h w=%b exp 0/1", p_i_rd, p_i_wr); else n_pass++;
    cyc(); cyc();
    @(negedge clk); reset_n = 1'b1;
    for (int k = 0; k < 10 && !got; k++) begin
      cyc(); @(negedge clk);
      if (p_m_read) nrd++;
      if (!p_i_wr) got = 1'b1;
    end
    n_chk++; if (got !== 1'b1) $display("FAIL t6_timeout: got done=%b exp 1", got); else n_pass++;
    n_chk++; if (p_i_rd !== 32'h5A5A_0060) $display("FAIL t6_data: got %h exp 5a5a0060", p_i_rd); else n_pass++;
    n_chk++; if (nrd !== 1) $display("FAIL t6_mread_cycles: got %0d exp 1", nrd); else n_pass++;
    cyc(); i_read = 1'b0;
    cyc();
  endtask

  initial begin
    reset_n = 1'b0;
    i_address = '0; i_read = 1'b0;
    d_address = '0; d_read = 1'b0; d_write = 1'b0; d_writedata = '0; d_byteenable = '0;
    m_waitrequest = 1'b0;
    test_reset();
    test_i_read();
    test_priority();
    test_round_robin();
    test_stall();
    test_byteenable();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
